pattern_player: RTL
===================

Name: pattern_player

Overview:
- Downstream consumer of the pattern buffer bank.
- Drives the bank's buffer-select and byte-pointer inputs, and reads the selected 27-byte buffer as a flattened bus.
- Streams bytes 0..len out over a valid/ready byte interface, optionally looping.
- Switches banks glitch-free, only at pattern boundaries (double-buffering, so software reloads one bank while another plays).

Parameters:
- DEPTH, 27, bytes per buffer
- WIDTH, 8, bits per byte
- PW, 5, pointer width (bufp)
- BW, 3, bank-select width (bufselect)

Ports:
- sclk  in  1  system clock; all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- cur_buf  in  DEPTH*WIDTH  selected buffer; byte i at [i*8+7:i*8]
- start  in  1  begin playback (pulse)
- stop  in  1  abort playback (pulse)
- loop  in  1  1 = wrap to byte 0 after last byte
- plen  in  PW  index of last byte; sampled at start
- bank_req  in  BW  requested bank
- bank_req_vld  in  1  bank_req strobe
- bufselect  out  BW  bank select to buffer bank
- bufp  out  PW  byte pointer to buffer bank
- dout  out  WIDTH  output byte (registered)
- dvalid  out  1  dout valid
- dready  in  1  consumer accepts dout
- dlast  out  1  dout is the pattern's last byte
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on natural completion

Behaviour:
- Reset (rst_n=0 at edge): state=IDLE; all outputs 0; length register 0; pending-bank register cleared. Reset mid-run aborts immediately; no done pulse.
- States:
  - IDLE: dvalid=0.
  - FETCH: one cycle; dout <= byte[bufp]; go to SEND.
  - SEND: dvalid=1 until accepted.
- Transfer: a byte is accepted on an edge where dvalid&dready=1.
- Start: start in IDLE (and stop=0) sets len_r = min(plen,26) and bufp=0. If a bank switch is pending, it is applied now (bufselect <= pend_bank, pending cleared). Then FETCH. Latency start -> first dvalid = 2 cycles.
- SEND, accept, bufp<len_r: bufp+1; dout <= byte[bufp+1] same edge; stay SEND. Full throughput of one byte per cycle.
- SEND, accept, bufp==len_r (dlast=1):
  - loop=1, no pending: bufp=0; dout <= byte[0]; stay SEND.
  - loop=1, pending: bufselect <= pend_bank; bufp=0; clear pending; go FETCH. Exactly one bubble cycle.
  - loop=0: go IDLE; dvalid=0; done=1 for one cycle.
- dlast = dvalid & (bufp==len_r).
- Backpressure: while dvalid&!dready, dout, dlast and bufp are held stable.
- Bank request: bank_req_vld at any time loads pend_bank; a later request overwrites an earlier one.
  - In IDLE: applied on the following edge.
  - Coincident with a wrap edge: the wrap uses the previously pending value (if any); the new value stays pending for the next boundary.
- stop (any non-IDLE state) -> IDLE next edge; dvalid=0; no done.
  - If stop coincides with an accept, that byte counts as transferred.
  - stop beats start in the same cycle.
  - bufp and bufselect retain their values.
- start while busy is ignored. plen changes while busy are ignored.
- cur_buf is assumed valid one cycle after a bufselect change; the FETCH bubble covers this.

Optional Feature:
- Macro: PATTERN_PLAYER_LOOPCNT_EN.
- Defined:
  - Adds output loops [15:0].
  - Cleared to 0 on reset and on accepted start.
  - Increments on every wrap (dlast accepted with loop=1); saturates at 16'hFFFF.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset: hold rst_n=0 three cycles with start=1 -> all outputs 0; busy=0; no dvalid.
- Single pass: byte i = 8'h10+i, plen=3, loop=0, dready=1, start pulse -> dvalid rises 2 cycles later.
  - dout = 10,11,12,13 on consecutive cycles; dlast only on 13.
  - done pulses on the cycle after 13 is accepted; busy drops with it.
- Backpressure: same setup, dready=0 for 3 cycles while dout=11 -> dout, bufp=1 and dlast=0 held stable; resumes with 12 after dready=1.
- Looped bank switch: plen=2, loop=1, bank 0 bytes A0..A2, bank 2 bytes B0..B2; bank_req=2 pulsed during byte A1.
  - Stream reads A0,A1,A2, then one cycle dvalid=0 with bufselect=2, then B0,B1,B2,B0...
  - With LOOPCNT_EN: loops increments once per wrap.
- Stop mid-run: stop asserted while dout=12 and dready=0 -> next cycle IDLE, dvalid=0, no done pulse; bufp stays 2.
- Clamp/conflict: plen=31 -> last byte index 26 (27 bytes, dlast on byte 26). start and stop in the same cycle -> stays IDLE.

Source files
------------

// File: rtl/pattern_player.sv
// pattern_player: streams a pattern buffer over valid/ready with looping and boundary bank switching; PATTERN_PLAYER_LOOPCNT_EN adds a loops counter
module pattern_player #(
  parameter int DEPTH = 27,
  parameter int WIDTH = 8,
  parameter int PW = 5,
  parameter int BW = 3
) (
  input  logic                   sclk,
  input  logic                   rst_n,
  input  logic [DEPTH*WIDTH-1:0] cur_buf,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   loop,
  input  logic [PW-1:0]          plen,
  input  logic [BW-1:0]          bank_req,
  input  logic                   bank_req_vld,
  output logic [BW-1:0]          bufselect,
  output logic [PW-1:0]          bufp,
  output logic [WIDTH-1:0]       dout,
  output logic                   dvalid,
  input  logic                   dready,
  output logic                   dlast,
  output logic                   busy,
`ifdef PATTERN_PLAYER_LOOPCNT_EN
  output logic [15:0]            loops,
`endif
  output logic                   done
);
  typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  state_t state, state_n;
  logic [PW-1:0] len_r, bufp_n, rd_idx;
  logic [BW-1:0] pend_bank;
  logic pend_vld, go, ld, apply, wrap, done_n;
  assign dvalid = state == SEND;
  assign dlast = dvalid && bufp == len_r;
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    bufp_n = bufp;
    rd_idx = bufp;
    go = 1'b0;
    ld = 1'b0;
    apply = 1'b0;
    wrap = 1'b0;
    done_n = 1'b0;
    if (state == IDLE) begin
      apply = pend_vld;
      go = start && !stop;
      state_n = go ? FETCH : IDLE;
      bufp_n = go ? '0 : bufp;
    end else if (stop) begin
      state_n = IDLE;
    end else if (state == FETCH) begin
      ld = 1'b1;
      state_n = SEND;
    end else if (dready) begin
      wrap = dlast && loop;
      done_n = dlast && !loop;
      bufp_n = !dlast ? bufp + PW'(1) : loop ? '0 : bufp;
      rd_idx = bufp_n;
      ld = !dlast || (loop && !pend_vld);
      apply = wrap && pend_vld;
      state_n = done_n ? IDLE : apply ? FETCH : SEND;
    end
  end
  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      state <= IDLE;
      len_r <= '0;
      bufp <= '0;
      bufselect <= '0;
      dout <= '0;
      done <= 1'b0;
      pend_bank <= '0;
      pend_vld <= 1'b0;
    end else begin
      state <= state_n;
      bufp <= bufp_n;
      done <= done_n;
      if (go) len_r <= plen > LAST ? LAST : plen;
      if (apply) bufselect <= pend_bank;
      if (ld) dout <= cur_buf[rd_idx*WIDTH +: WIDTH];
      if (bank_req_vld) begin
        pend_bank <= bank_req;
        pend_vld <= 1'b1;
      end else if (apply) begin
        pend_vld <= 1'b0;
      end
    end
  end
`ifdef PATTERN_PLAYER_LOOPCNT_EN
  always_ff @(posedge sclk) begin
    if (!rst_n || go) loops <= '0;
    else if (wrap && loops != 16'hFFFF) loops <= loops + 16'd1;
  end
`endif
endmodule
